// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared MIPS register-file constants: widths, register names, writeback source ids.
// Imported by the writeback arbiter, its interface and the bench.
package mips_rf_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NREG   = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [ADDR_W-1:0] REG_AT = 5'd1,  REG_V0 = 5'd2,  REG_V1 = 5'd3;
    localparam logic [ADDR_W-1:0] REG_A0 = 5'd4,  REG_A1 = 5'd5,  REG_A2 = 5'd6,  REG_A3 = 5'd7;
    localparam logic [ADDR_W-1:0] REG_T0 = 5'd8,  REG_T1 = 5'd9,  REG_T2 = 5'd10, REG_T3 = 5'd11;
    localparam logic [ADDR_W-1:0] REG_T4 = 5'd12, REG_T5 = 5'd13, REG_T6 = 5'd14, REG_T7 = 5'd15;
    localparam logic [ADDR_W-1:0] REG_S0 = 5'd16, REG_S1 = 5'd17, REG_S2 = 5'd18, REG_S3 = 5'd19;
    localparam logic [ADDR_W-1:0] REG_S4 = 5'd20, REG_S5 = 5'd21, REG_S6 = 5'd22, REG_S7 = 5'd23;
    localparam logic [ADDR_W-1:0] REG_T8 = 5'd24, REG_T9 = 5'd25, REG_K0 = 5'd26, REG_K1 = 5'd27;
    localparam logic [ADDR_W-1:0] REG_GP = 5'd28, REG_SP = 5'd29, REG_FP = 5'd30, REG_RA = 5'd31;

    localparam int WB_ALU    = 0;
    localparam int WB_LOAD   = 1;
    localparam int WB_MULDIV = 2;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: per-requester valid/ready/addr/data in, register-file write port and
// pending scoreboard out. master = writeback sources + regfile side, slave = arbiter.
interface regfile_wb_arbiter_if
    import mips_rf_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int DATA_W_P = DATA_W,
    parameter int ADDR_W_P = ADDR_W
);
    logic [NREQ-1:0]          req_valid;
    logic [NREQ*ADDR_W_P-1:0] req_addr;
    logic [NREQ*DATA_W_P-1:0] req_data;
    logic [NREQ-1:0]          req_ready;
    logic                     wr_en;
    logic [ADDR_W_P-1:0]      wr_addr;
    logic [DATA_W_P-1:0]      wr_data;
    logic [NREG-1:0]          pending;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, wr_en, wr_addr, wr_data, pending
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, wr_en, wr_addr, wr_data, pending
    );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin pick among asserted requests, searching upward from i_ptr with wrap.
// Latency: combinational; backpressure: none, pointer state lives in the parent.
module rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_grant,
    output logic [PTR_W-1:0] o_grant_idx,
    output logic             o_grant_vld
);
    int w_cand;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_vld = 1'b0;
        w_cand      = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = (int'(i_ptr) + k) % NREQ;
            if (!o_grant_vld && i_req[w_cand]) begin
                o_grant[w_cand] = 1'b1;
                o_grant_idx     = PTR_W'(w_cand);
                o_grant_vld     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NREQ writeback sources via one-entry buffers.
// Latency: 1 cycle accept->wr_en; backpressure: req_ready = buffer empty or draining now.
module regfile_wb_arbiter
    import mips_rf_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int DATA_W_P = DATA_W,
    parameter int ADDR_W_P = ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]     r_buf_valid;
    logic [ADDR_W_P-1:0] r_buf_addr [NREQ];
    logic [DATA_W_P-1:0] r_buf_data [NREQ];
    logic [PTR_W-1:0]    r_rr_ptr;
    logic                r_wr_en;
    logic [ADDR_W_P-1:0] r_wr_addr;
    logic [DATA_W_P-1:0] r_wr_data;

    logic [NREQ-1:0]     w_grant;
    logic [PTR_W-1:0]    w_grant_idx;
    logic                w_grant_vld;
    logic [NREQ-1:0]     w_ready;
    logic [NREQ-1:0]     w_accept;
    logic [NREG-1:0]     w_pending;

    rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_rr_arbiter (
        .i_req       (r_buf_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_grant_vld (w_grant_vld)
    );

    // Ready depends only on state, so a granted buffer can refill on the same edge.
    assign w_ready  = ~r_buf_valid | w_grant;
    assign w_accept = bus.req_valid & w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_valid <= '0;
            for (int i = 0; i < NREQ; i++) begin
                r_buf_addr[i] <= '0;
                r_buf_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (flush) begin
                    r_buf_valid[i] <= 1'b0;
                end else if (w_accept[i]) begin
                    r_buf_valid[i] <= 1'b1;
                    r_buf_addr[i]  <= bus.req_addr[i*ADDR_W_P +: ADDR_W_P];
                    r_buf_data[i]  <= bus.req_data[i*DATA_W_P +: DATA_W_P];
                end else if (w_grant[i]) begin
                    r_buf_valid[i] <= 1'b0;
                end
            end
        end
    end

    // A grant to $zero is consumed like any other but never raises wr_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr  <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (!flush && w_grant_vld) begin
            r_wr_en   <= (r_buf_addr[w_grant_idx] != ADDR_W_P'(REG_ZERO));
            r_wr_addr <= r_buf_addr[w_grant_idx];
            r_wr_data <= r_buf_data[w_grant_idx];
            r_rr_ptr  <= (w_grant_idx == PTR_W'(NREQ - 1)) ? '0 : w_grant_idx + PTR_W'(1);
        end else begin
            r_wr_en <= 1'b0;
        end
    end

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_buf_valid[i]) begin
                w_pending[r_buf_addr[i]] = 1'b1;
            end
        end
        if (r_wr_en) begin
            w_pending[r_wr_addr] = 1'b1;
        end
        w_pending[0] = 1'b0;
    end

    assign bus.req_ready = w_ready;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.pending   = w_pending;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single write, contention, $zero, flush, refill.
module tb_regfile_wb_arbiter;
    import mips_rf_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   tests  = 0;
    int   failed = 0;

    regfile_wb_arbiter_if #(.NREQ(3)) bus ();

    regfile_wb_arbiter #(.NREQ(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    int          seq_addr [6] = '{2, 3, 4, 2, 3, 4};
    logic [2:0]  exp_rdy;

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;

        // Reset state
        tick(); tick();
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_pending", bus.pending, 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'h7);
        rst_n = 1'b1;
        tick();
        chk("post_rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("post_rst_ready", 32'(bus.req_ready), 32'h7);

        // Contention from rr_ptr = 0, addrs 2/3/4 re-presented every cycle
        bus.req_valid = 3'b111;
        bus.req_addr  = {5'd4, 5'd3, 5'd2};
        bus.req_data  = {32'hC4C4C4C4, 32'hB3B3B3B3, 32'hA2A2A2A2};
        chk("cont_ready0", 32'(bus.req_ready), 32'h7);
        tick();
        chk("cont_ready1", 32'(bus.req_ready), 32'h1);
        chk("cont_pending", bus.pending, 32'h0000_001C);
        for (int j = 0; j < 6; j++) begin
            tick();
            exp_rdy = 3'(1 << ((j + 1) % 3));
            chk($sformatf("cont_wr_en_%0d", j), 32'(bus.wr_en), 32'd1);
            chk($sformatf("cont_wr_addr_%0d", j), 32'(bus.wr_addr), 32'(seq_addr[j]));
            chk($sformatf("cont_ready_%0d", j), 32'(bus.req_ready), 32'(exp_rdy));
        end
        bus.req_valid = '0;
        tick(); tick(); tick(); tick();
        chk("cont_drain_wr_en", 32'(bus.wr_en), 32'd0);
        chk("cont_drain_ready", 32'(bus.req_ready), 32'h7);

        // Single ALU write to t0 (rr_ptr back at 0)
        bus.req_valid = 3'b001;
        bus.req_addr  = {5'd0, 5'd0, REG_T0};
        bus.req_data  = {32'd0, 32'd0, 32'hDEADBEEF};
        chk("single_ready", 32'(bus.req_ready[WB_ALU]), 32'd1);
        tick();
        bus.req_valid = '0;
        chk("single_wr_en_k", 32'(bus.wr_en), 32'd0);
        chk("single_pend_k", 32'(bus.pending[8]), 32'd1);
        tick();
        chk("single_wr_en", 32'(bus.wr_en), 32'd1);
        chk("single_wr_addr", 32'(bus.wr_addr), 32'd8);
        chk("single_wr_data", bus.wr_data, 32'hDEADBEEF);
        chk("single_pend_wr", 32'(bus.pending[8]), 32'd1);
        tick();
        chk("single_wr_en_off", 32'(bus.wr_en), 32'd0);
        chk("single_pend_off", bus.pending, 32'd0);

        // $zero write by load unit (rr_ptr = 1)
        bus.req_valid = 3'b010;
        bus.req_addr  = {5'd0, REG_ZERO, 5'd0};
        bus.req_data  = {32'd0, 32'h0000_1234, 32'd0};
        chk("zero_ready", 32'(bus.req_ready[WB_LOAD]), 32'd1);
        tick();
        bus.req_valid = '0;
        chk("zero_wr_en_a", 32'(bus.wr_en), 32'd0);
        chk("zero_pending", bus.pending, 32'd0);
        tick();
        chk("zero_wr_en_b", 32'(bus.wr_en), 32'd0);
        chk("zero_drained", 32'(bus.req_ready), 32'h7);
        // rr_ptr should now be 2: mul/div beats ALU
        bus.req_valid = 3'b101;
        bus.req_addr  = {5'd11, 5'd0, 5'd10};
        bus.req_data  = {32'h1111_0011, 32'd0, 32'h1111_0010};
        tick();
        bus.req_valid = '0;
        chk("ptr_pending", bus.pending, 32'h0000_0C00);
        tick();
        chk("ptr_first_addr", 32'(bus.wr_addr), 32'd11);
        chk("ptr_first_data", bus.wr_data, 32'h1111_0011);
        tick();
        chk("ptr_second_addr", 32'(bus.wr_addr), 32'd10);
        tick();
        chk("ptr_idle", 32'(bus.wr_en), 32'd0);

        // Flush with write to 9 in the output stage, buffers 16/17 full (rr_ptr = 1)
        bus.req_valid = 3'b001;
        bus.req_addr  = {5'd0, 5'd0, REG_T1};
        bus.req_data  = {32'd0, 32'd0, 32'h0000_0009};
        tick();
        bus.req_valid = 3'b110;
        bus.req_addr  = {REG_S1, REG_S0, 5'd0};
        bus.req_data  = {32'h0000_0017, 32'h0000_0016, 32'd0};
        tick();
        bus.req_valid = '0;
        flush = 1'b1;
        chk("flush_wr_en9", 32'(bus.wr_en), 32'd1);
        chk("flush_wr_addr9", 32'(bus.wr_addr), 32'd9);
        chk("flush_pend_pre", bus.pending, 32'h0003_0200);
        tick();
        flush = 1'b0;
        chk("flush_pending", bus.pending, 32'd0);
        chk("flush_ready", 32'(bus.req_ready), 32'h7);
        chk("flush_no_wr_a", 32'(bus.wr_en), 32'd0);
        tick();
        chk("flush_no_wr_b", 32'(bus.wr_en), 32'd0);
        tick();

        // Back-to-back ALU refill, addrs 5/6/7
        bus.req_valid = 3'b001;
        bus.req_addr  = {5'd0, 5'd0, 5'd5};
        bus.req_data  = {32'd0, 32'd0, 32'h0000_0505};
        chk("b2b_ready0", 32'(bus.req_ready[WB_ALU]), 32'd1);
        tick();
        bus.req_addr  = {5'd0, 5'd0, 5'd6};
        bus.req_data  = {32'd0, 32'd0, 32'h0000_0606};
        chk("b2b_ready1", 32'(bus.req_ready[WB_ALU]), 32'd1);
        tick();
        bus.req_addr  = {5'd0, 5'd0, 5'd7};
        bus.req_data  = {32'd0, 32'd0, 32'h0000_0707};
        chk("b2b_addr5", 32'(bus.wr_addr), 32'd5);
        chk("b2b_ready2", 32'(bus.req_ready[WB_ALU]), 32'd1);
        tick();
        bus.req_valid = '0;
        chk("b2b_en6", 32'(bus.wr_en), 32'd1);
        chk("b2b_addr6", 32'(bus.wr_addr), 32'd6);
        tick();
        chk("b2b_en7", 32'(bus.wr_en), 32'd1);
        chk("b2b_addr7", 32'(bus.wr_addr), 32'd7);
        chk("b2b_data7", bus.wr_data, 32'h0000_0707);
        tick();
        chk("b2b_idle", 32'(bus.wr_en), 32'd0);

        // Asynchronous reset mid-traffic with all buffers full
        bus.req_valid = 3'b111;
        bus.req_addr  = {5'd22, 5'd21, 5'd20};
        bus.req_data  = {32'h22, 32'h21, 32'h20};
        tick();
        tick();
        chk("mid_wr_en", 32'(bus.wr_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("arst_pending", bus.pending, 32'd0);
        bus.req_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_ready", 32'(bus.req_ready), 32'h7);
        chk("arst_wr_en_after", 32'(bus.wr_en), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single write port of the MIPS 32-entry register file between NREQ writeback sources (ALU, load unit, multiply/divide unit). Each source hands over one (address, data) pair through a valid/ready handshake into a private one-entry buffer. A round-robin arbiter drains one buffer per cycle into a registered write port that drives the register file's write-enable decoder. A pending-write scoreboard is exported for hazard detection.

## Interface
Parameters:
- NREQ, 3, number of writeback requesters (index 0 = ALU, 1 = load, 2 = mul/div)
- DATA_W, 32, register data width
- ADDR_W, 5, register index width

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; discards all buffered, not-yet-granted entries
- req_valid  in  NREQ  requester i presents a write
- req_addr  in  NREQ*ADDR_W  destination register per requester, packed, requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  NREQ*DATA_W  write data per requester, packed likewise
- req_ready  out  NREQ  buffer i can accept this cycle
- wr_en  out  1  register-file write enable (feeds the write-enable decoder's in)
- wr_addr  out  ADDR_W  register-file write index (feeds decoder sel)
- wr_data  out  DATA_W  register-file write data
- pending  out  32  bit r set while any buffered or output-stage write targets register r

## Operation
- Per requester: buf_valid, buf_addr, buf_data.
- Accept: req_valid[i] & req_ready[i] at an edge loads buffer i.
- req_ready[i] = !buf_valid[i] | grant[i]. This is combinational and independent of req_valid[i]. Simultaneous grant and accept on the same edge refills the buffer with no bubble.
- Arbitration: among buffers with buf_valid set, grant one per cycle, round-robin. The search starts at rr_ptr and wraps past NREQ-1 to 0. After granting i, rr_ptr = (i+1) mod NREQ; with no grant, rr_ptr holds.
- Output stage: on a grant, the next edge loads wr_addr/wr_data from the granted buffer and sets wr_en = 1, except when buf_addr == 0 ($zero). Such a write is granted and consumed but leaves wr_en = 0. With no grant, wr_en = 0 and wr_addr/wr_data hold their values.
- Same-register ordering across requesters is not enforced. Issue logic must consult pending before issuing a second write to the same register.
- pending[r] = OR over i of (buf_valid[i] & buf_addr[i]==r), OR (wr_en & wr_addr==r). This is combinational from state. pending[0] is always 0.
- flush: at the edge, clears all buf_valid and ignores same-cycle accepts and grants. The output stage is not affected: a write already in wr_en completes. rr_ptr is held.
- Reset (any time, asynchronous): buf_valid = 0, rr_ptr = 0, wr_en = 0, wr_addr = 0, wr_data = 0. Therefore pending = 0 and req_ready = all ones once rst_n rises.

## Timing
- Accept at edge k → grant evaluated in cycle k..k+1 → wr_en high from edge k+1 to edge k+2 → register file captures at edge k+2. Minimum latency is 1 cycle from accept to wr_en.
- Throughput is 1 write per cycle aggregate. With a requester re-presenting every cycle, it sustains 1/NREQ under full contention, and 1 write per cycle when it is the only requester.
- The worst-case wait from buffer-valid to grant is NREQ-1 cycles, which guarantees no starvation.
- req_ready has a combinational path from buf_valid and rr_ptr only. There is no path from req_valid.
- flush together with rst_n low: reset dominates.

## Structure
- Shared package mips_rf_pkg holds:
  - ADDR_W and DATA_W
  - REG_ZERO = 5'd0
  - named register-index constants (REG_AT … REG_RA, 1…31)
  - requester index constants WB_ALU = 0, WB_LOAD = 1, WB_MULDIV = 2
- Sub-module rr_arbiter (NREQ): inputs req vector and rr_ptr; outputs one-hot grant and grant index. It is purely combinational; rr_ptr is owned by the parent.

## Test plan
- Reset: assert rst_n low mid-traffic with all buffers full. Required response: immediately wr_en = 0 and pending = 0; after release, req_ready = 3'b111.
- Single write: ALU writes addr 8 (t0), data 0xDEADBEEF. Required response: wr_en = 1, wr_addr = 8, wr_data = 0xDEADBEEF exactly one cycle after accept; pending[8] = 1 from the accept edge until the cycle after wr_en drops.
- Contention: all three requesters valid every cycle (addrs 2, 3, 4) from rr_ptr = 0. Required response: wr_addr sequence is 2, 3, 4, 2, 3, 4 with wr_en continuously high, and each req_ready high only in its granted cycle.
- $zero write: load unit writes addr 0, data 0x1234. Required response: accepted (ready high, buffer drains in 1 cycle), wr_en stays 0, pending[0] stays 0, and rr_ptr advances to 2.
- Flush: load and mul/div buffers full (addrs 16, 17) while wr_en is high for addr 9, then flush. Required response: the write to 9 completes, no writes to 16 or 17 occur, and pending[16] = pending[17] = 0 after the edge.
- Back-to-back refill: ALU alone, valid every cycle with addrs 5, 6, 7. Required response: req_ready stays high, and wr_addr is 5, 6, 7 on consecutive cycles with no bubble.
